wb_loader_master: RTL

//  Wishbone initiator that drives the mainboard 8-bit debug/load bus (ROM, GROM, VDP RAM pages).

---
 rtl/wb_loader_master_pkg.sv | 26 ++
 rtl/wb_loader_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_loader_master_pkg.sv
// Shared constants for the Wishbone loader master: FSM states, command fields and status bytes.
package wb_loader_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr0,
    StAddr1,
    StAddr2,
    StWdata,
    StWbcyc,
    StRsend,
    StWstat
  } state_e;

  // Bit 0 of the [0:7] command byte is its MSB.
  localparam int unsigned CmdWBit = 0;

  localparam logic [7:0] StatOk      = 8'h00;
  localparam logic [7:0] StatTimeout = 8'hE1;
  localparam logic [7:0] RdTimeout   = 8'hFF;

  localparam logic [7:0] PageVdp  = 8'h00;
  localparam logic [7:0] PageRom  = 8'h01;
  localparam logic [7:0] PageGrom = 8'h02;

endpackage

// File: rtl/wb_loader_master.sv
// Host byte-stream to Wishbone classic bridge: framed commands become single-byte WB cycles with an
// auto-incrementing address; read data and write status are returned on the tx stream.
module wb_loader_master
  import wb_loader_master_pkg::*;
#(
  parameter int unsigned ack_timeout = 255,
  parameter int unsigned addr_bits   = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [0:7]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [0:7]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [0:addr_bits-1] wb_adr_o,
  output logic [0:7]           wb_dat_o,
  input  logic [0:7]           wb_dat_i,
  output logic                 wb_we_o,
  output logic [0:0]           wb_sel_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic                 wb_ack_i,
  output logic                 busy,
  output logic                 error
);

  state_e      state_q, state_d;
  logic        alive_q;
  logic        we_q;
  logic [6:0]  cnt_q;
  logic [23:0] adr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        stb_q;
  logic [15:0] timer_q;
  logic        error_q;

  logic rx_fire;
  logic tmo;
  logic wb_done;

  // rx_ready stays low for the first cycle out of reset so every output reads 0 during reset.
  always_comb begin
    rx_ready = 1'b0;
    if (alive_q) begin
      case (state_q)
        StIdle, StAddr0, StAddr1, StAddr2, StWdata: rx_ready = 1'b1;
        default:                                    rx_ready = 1'b0;
      endcase
    end
  end

  assign rx_fire = rx_valid & rx_ready;
  assign tmo     = (timer_q == 16'(ack_timeout - 1));
  assign wb_done = stb_q & (wb_ack_i | tmo);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rx_fire) state_d = StAddr0;
      StAddr0: if (rx_fire) state_d = StAddr1;
      StAddr1: if (rx_fire) state_d = StAddr2;
      StAddr2: if (rx_fire) state_d = we_q ? StWdata : StWbcyc;
      StWdata: if (rx_fire) state_d = StWbcyc;
      StWbcyc: begin
        if (wb_done) begin
          if (!we_q)            state_d = StRsend;
          else if (cnt_q != '0) state_d = StWdata;
          else                  state_d = StWstat;
        end
      end
      StRsend: if (tx_ready) state_d = (cnt_q != '0) ? StWbcyc : StIdle;
      StWstat: if (tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // cnt_q holds remaining-1; it is decremented when leaving a beat that has another one after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      unique case (1'b1)
        state_q == StIdle: begin
          if (rx_fire) begin
            we_q    <= rx_data[CmdWBit];
            cnt_q   <= rx_data[1:7];
            error_q <= 1'b0;
          end
        end
        state_q == StAddr0: if (rx_fire) adr_q[23:16] <= rx_data;
        state_q == StAddr1: if (rx_fire) adr_q[15:8]  <= rx_data;
        state_q == StAddr2: if (rx_fire) adr_q[7:0]   <= rx_data;
        state_q == StWdata: if (rx_fire) wdata_q      <= rx_data;
        state_q == StWbcyc: begin
          if (wb_done) begin
            // Upper bits beyond addr_bits are never driven out, so wrap is implicit.
            adr_q <= adr_q + 24'd1;
            if (!wb_ack_i) error_q <= 1'b1;
            if (!we_q)     rdata_q <= wb_ack_i ? wb_dat_i : RdTimeout;
            if (we_q && cnt_q != '0) cnt_q <= cnt_q - 7'd1;
          end
        end
        state_q == StRsend: if (tx_ready && cnt_q != '0) cnt_q <= cnt_q - 7'd1;
        default: ;
      endcase
    end
  end

  // Strobe rises the cycle after WBCYC entry and drops on the edge that completes the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      if (stb_q) begin
        stb_q   <= !wb_done;
        timer_q <= wb_done ? '0 : timer_q + 16'd1;
      end else begin
        stb_q   <= (state_q == StWbcyc);
        timer_q <= '0;
      end
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    if (state_q == StRsend) begin
      tx_valid = 1'b1;
      tx_data  = rdata_q;
    end else if (state_q == StWstat) begin
      tx_valid = 1'b1;
      tx_data  = error_q ? StatTimeout : StatOk;
    end
  end

  assign wb_adr_o = adr_q[addr_bits-1:0];
  assign wb_dat_o = wdata_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q;
  assign busy     = (state_q != StIdle);
  assign error    = error_q;

endmodule
